// File: rtl/voice_mixer.sv
// Serial voice mixer: snapshot, DC-offset removal, master volume, saturation to offset-binary.
// Optional first-order delta-sigma output enabled by defining VOICE_MIXER_PDM_EN.
module voice_mixer #(
  parameter int NUM_VOICES  = 4,
  parameter int VOICE_BITS  = 12,
  parameter int OUT_BITS    = 12,
  parameter int VOLUME_BITS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_strobe,
  input  logic [NUM_VOICES*VOICE_BITS-1:0] voices_in,
  input  logic [NUM_VOICES-1:0]            voice_mute,
  input  logic [VOLUME_BITS-1:0]           master_volume,
  output logic [OUT_BITS-1:0]              dout,
  output logic                             dout_valid,
  output logic                             busy,
  output logic                             clip,
  output logic                             overrun,
  output logic                             pdm_out
);

  localparam int IDX_BITS  = $clog2(NUM_VOICES);
  localparam int ACC_BITS  = VOICE_BITS + IDX_BITS;
  localparam int PROD_BITS = ACC_BITS + VOLUME_BITS + 1;

  localparam logic [IDX_BITS-1:0]          LAST_IDX  = IDX_BITS'(NUM_VOICES - 1);
  localparam logic [VOICE_BITS-1:0]        VOICE_MID = {1'b1, {(VOICE_BITS-1){1'b0}}};
  localparam logic [OUT_BITS-1:0]          OUT_MID   = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic signed [PROD_BITS-1:0]  SAT_MAX   = PROD_BITS'((64'sd1 <<< (OUT_BITS-1)) - 64'sd1);
  localparam logic signed [PROD_BITS-1:0]  SAT_MIN   = PROD_BITS'(-(64'sd1 <<< (OUT_BITS-1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                          state_r;
  logic [NUM_VOICES*VOICE_BITS-1:0] voices_r;
  logic [NUM_VOICES-1:0]           mute_r;
  logic [VOLUME_BITS-1:0]          volume_r;
  logic [IDX_BITS-1:0]             idx_r;
  logic signed [ACC_BITS-1:0]      acc_r;
  logic signed [PROD_BITS-1:0]     prod_r;
  logic [OUT_BITS-1:0]             dout_r;
  logic                            dout_valid_r;
  logic                            busy_r;
  logic                            clip_r;
  logic                            overrun_r;

  logic [VOICE_BITS-1:0]           voice_sel_s;
  logic signed [VOICE_BITS:0]      voice_ofs_s;
  logic signed [ACC_BITS-1:0]      voice_term_s;
  logic signed [PROD_BITS-1:0]     prod_s;
  logic signed [PROD_BITS-1:0]     res_s;
  logic [OUT_BITS-1:0]             out_code_s;
  logic                            clip_s;

  assign voice_sel_s = voices_r[idx_r*VOICE_BITS +: VOICE_BITS];
  assign voice_ofs_s = $signed({1'b0, voice_sel_s}) - $signed({1'b0, VOICE_MID});
  assign prod_s      = PROD_BITS'(acc_r) * PROD_BITS'($signed({1'b0, volume_r}));
  assign res_s       = prod_r >>> VOLUME_BITS;

  // Signed contribution of the voice currently addressed by idx_r
  always_comb begin
    voice_term_s = '0;
    if (mute_r[idx_r]) begin
      voice_term_s = '0;
    end else begin
      voice_term_s = ACC_BITS'(voice_ofs_s);
    end
  end

  // Saturate the scaled sum; adding midscale to a two's-complement code just flips its MSB
  always_comb begin
    out_code_s = OUT_MID;
    clip_s     = 1'b0;
    if (res_s > SAT_MAX) begin
      out_code_s = {OUT_BITS{1'b1}};
      clip_s     = 1'b1;
    end else if (res_s < SAT_MIN) begin
      out_code_s = {OUT_BITS{1'b0}};
      clip_s     = 1'b1;
    end else begin
      out_code_s = res_s[OUT_BITS-1:0] ^ OUT_MID;
      clip_s     = 1'b0;
    end
  end

  // Mix sequencer: snapshot, accumulate one voice per clock, scale, then publish
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      voices_r     <= '0;
      mute_r       <= '0;
      volume_r     <= '0;
      idx_r        <= '0;
      acc_r        <= '0;
      prod_r       <= '0;
      dout_r       <= OUT_MID;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      clip_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      dout_valid_r <= 1'b0;
      if (sample_strobe && busy_r) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (sample_strobe) begin
            voices_r <= voices_in;
            mute_r   <= voice_mute;
            volume_r <= master_volume;
            idx_r    <= '0;
            acc_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= ACC;
          end
        end
        ACC: begin
          acc_r <= acc_r + voice_term_s;
          if (idx_r == LAST_IDX) begin
            state_r <= SCALE;
          end else begin
            idx_r <= idx_r + IDX_BITS'(1);
          end
        end
        SCALE: begin
          prod_r  <= prod_s;
          state_r <= OUT;
        end
        OUT: begin
          dout_r       <= out_code_s;
          clip_r       <= clip_s;
          dout_valid_r <= 1'b1;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign clip       = clip_r;
  assign overrun    = overrun_r;

`ifdef VOICE_MIXER_PDM_EN
  logic [OUT_BITS:0] pdm_acc_r;

  // First-order delta-sigma: the carry out of the phase accumulator is the bitstream
  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_acc_r <= '0;
    end else begin
      pdm_acc_r <= {1'b0, pdm_acc_r[OUT_BITS-1:0]} + {1'b0, dout_r};
    end
  end

  assign pdm_out = pdm_acc_r[OUT_BITS];
`else
  assign pdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized scoreboard bench for voice_mixer: a stimulus process queues expected
// samples from an arithmetic model, a negedge monitor pops and compares on dout_valid.
module tb_voice_mixer;

  localparam int NV = 4;
  localparam int VB = 12;
  localparam int OB = 12;
  localparam int WB = 4;
  localparam int LATENCY = NV + 3;

  logic              clk;
  logic              rst;
  logic              sample_strobe;
  logic [NV*VB-1:0]  voices_in;
  logic [NV-1:0]     voice_mute;
  logic [WB-1:0]     master_volume;
  logic [OB-1:0]     dout;
  logic              dout_valid;
  logic              busy;
  logic              clip;
  logic              overrun;
  logic              pdm_out;

  typedef struct {
    int d;
    int c;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   cyc;

  voice_mixer #(.NUM_VOICES(NV), .VOICE_BITS(VB), .OUT_BITS(OB), .VOLUME_BITS(WB)) dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .voices_in(voices_in),
    .voice_mute(voice_mute), .master_volume(master_volume), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .clip(clip), .overrun(overrun), .pdm_out(pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: signed sum of unmuted offsets, times volume, floor-divided by 2^WB, clamped
  function automatic void model(input logic [NV*VB-1:0] v, input logic [NV-1:0] m,
                                input logic [WB-1:0] vol, output int d, output int c);
    int sum;
    int prod;
    int res;
    int lim;
    sum = 0;
    for (int k = 0; k < NV; k++) begin
      if (!m[k]) sum += int'(v[k*VB +: VB]) - (1 << (VB-1));
    end
    prod = sum * int'(vol);
    res  = prod >>> WB;
    lim  = 1 << (OB-1);
    if (res > lim - 1) begin
      d = (1 << OB) - 1; c = 1;
    end else if (res < -lim) begin
      d = 0; c = 1;
    end else begin
      d = res + lim; c = 0;
    end
  endfunction

  function automatic logic [NV*VB-1:0] mk(input int a, input int b, input int c, input int e);
    logic [NV*VB-1:0] v;
    v = {VB'(e), VB'(c), VB'(b), VB'(a)};
    return v;
  endfunction

  function automatic logic [NV*VB-1:0] rand_voices();
    logic [NV*VB-1:0] v;
    for (int k = 0; k < NV; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k*VB +: VB] = '0;
        1:       v[k*VB +: VB] = '1;
        default: v[k*VB +: VB] = VB'($urandom_range(0, (1 << VB) - 1));
      endcase
    end
    return v;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", int'(dout_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dout", int'(dout), e.d);
        chk("clip", int'(clip), e.c);
        chk("latency", cyc - e.cyc, LATENCY);
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!dout_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!dout_valid) chk("valid_timeout", int'(dout_valid), 1);
  endtask

  task automatic do_mix(input logic [NV*VB-1:0] v, input logic [NV-1:0] m, input logic [WB-1:0] vol);
    exp_t e;
    @(posedge clk); #1;
    voices_in = v; voice_mute = m; master_volume = vol; sample_strobe = 1'b1;
    model(v, m, vol, e.d, e.c);
    e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    voices_in = rand_voices();
    voice_mute = NV'($urandom);
    master_volume = WB'($urandom);
    @(negedge clk);
    chk("busy_during_mix", int'(busy), 1);
    wait_valid();
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  initial begin
    int ones;
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; sample_strobe = 1'b0; voices_in = '0; voice_mute = '0; master_volume = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_dout", int'(dout), 2048);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_clip", int'(clip), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_pdm", int'(pdm_out), 0);

    do_mix(mk(2048, 2048, 2048, 2048), 4'b0000, 4'd15);
    do_mix(mk(3072, 2048, 2048, 2048), 4'b0000, 4'd15);
    do_mix(mk(4095, 4095, 4095, 4095), 4'b0000, 4'd15);
    do_mix(mk(0, 0, 0, 0), 4'b0000, 4'd15);
    do_mix(mk(3072, 1024, 2048, 2048), 4'b0010, 4'd8);
    do_mix(mk(3072, 1024, 2048, 2048), 4'b0000, 4'd8);
    do_mix(rand_voices(), 4'b0000, 4'd0);
    do_mix(mk(4095, 0, 4095, 0), 4'b0000, 4'd0);
    do_mix(rand_voices(), 4'b1111, 4'd15);
    chk("overrun_quiet", int'(overrun), 0);

    for (int i = 0; i < 30; i++) begin
      do_mix(rand_voices(), NV'($urandom_range(0, 3) == 0 ? $urandom : 0), WB'($urandom));
    end
    chk("overrun_still_quiet", int'(overrun), 0);

    // Overrun: second strobe three cycles into a mix is dropped
    begin
      exp_t e;
      logic [NV*VB-1:0] v;
      v = mk(3072, 2048, 2048, 2048);
      @(posedge clk); #1;
      voices_in = v; voice_mute = '0; master_volume = 4'd15; sample_strobe = 1'b1;
      model(v, 4'b0000, 4'd15, e.d, e.c);
      e.cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1 sample_strobe = 1'b0;
      @(posedge clk); #1;
      voices_in = mk(0, 0, 0, 0);
      @(posedge clk); #1 sample_strobe = 1'b1;
      @(posedge clk); #1 sample_strobe = 1'b0;
      wait_valid();
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("overrun_set", int'(overrun), 1);
      do_mix(rand_voices(), 4'b0000, WB'($urandom));
      @(negedge clk);
      chk("overrun_sticky", int'(overrun), 1);
    end

    // Reset during ACC abandons the mix
    @(posedge clk); #1;
    voices_in = mk(4095, 4095, 4095, 4095); master_volume = 4'd15; sample_strobe = 1'b1;
    @(posedge clk); #1 sample_strobe = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy_before", int'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_dout", int'(dout), 2048);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(dout_valid), 0);
    chk("rst_mid_overrun", int'(overrun), 0);
    rst = 1'b0;
    repeat (12) @(posedge clk);

    // Steady dout = 3072 for the bitstream density window
    do_mix(mk(4095, 2049, 2048, 2048), 4'b0000, 4'd8);
    repeat (3) @(posedge clk);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
`ifdef VOICE_MIXER_PDM_EN
    chk("pdm_ones", ones, 3072);
`else
    chk("pdm_ones", ones, 0);
`endif

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
